// File: rtl/nurse_call_arbiter.sv
// Nurse-call scheduler: latches bed call edges and presents one pending call at a time, with a wait alarm.
// Optional round-robin arbitration is enabled by defining NURSE_CALL_RR_EN; fixed priority (bed 0 first) otherwise.
module nurse_call_arbiter #(
    parameter int unsigned N_BEDS  = 3,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BEDS-1:0] call,
    input  logic              ack,
    output logic [N_BEDS-1:0] led,
    output logic              serve_valid,
    output logic [ID_W-1:0]   serve_id,
    output logic              alarm,
    output logic [CNT_W-1:0]  served_cnt
);

    localparam int unsigned WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_nxt;
    logic [N_BEDS-1:0] call_d;
    logic [N_BEDS-1:0] pending;
    logic [N_BEDS-1:0] rise;
    logic [N_BEDS-1:0] clr;
    logic [WC_W-1:0]   wait_cnt;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   last_ptr;
    logic              done;

    // First pending bed strictly after ptr, wrapping; ptr itself is examined last.
    function automatic logic [ID_W-1:0] pick_fn(input logic [N_BEDS-1:0] req,
                                                 input logic [ID_W-1:0]   ptr);
        logic [ID_W-1:0]   r;
        logic              found;
        logic [N_BEDS-1:0] sh;
        int unsigned       idx;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= N_BEDS; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_BEDS) idx = idx - N_BEDS;
            sh = req >> idx;
            if (!found && sh[0]) begin
                r     = ID_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

`ifdef NURSE_CALL_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      last_ptr <= '0;
        else if (done) last_ptr <= serve_id;
    end
`else
    // Fixed priority is the same search with the pointer parked on the last bed.
    assign last_ptr = ID_W'(N_BEDS - 1);
`endif

    assign pick = pick_fn(pending, last_ptr);
    assign rise = call & ~call_d;
    assign clr  = done ? (N_BEDS'(1) << serve_id) : '0;
    assign led  = pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        serve_valid = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) state_nxt = GRANT;
            end
            GRANT: begin
                serve_valid = 1'b1;
                if (ack) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            call_d     <= '0;
            pending    <= '0;
            serve_id   <= '0;
            wait_cnt   <= '0;
            alarm      <= 1'b0;
            served_cnt <= '0;
        end else begin
            call_d  <= call;
            pending <= (pending & ~clr) | rise;
            if (state == IDLE) begin
                wait_cnt <= '0;
                alarm    <= 1'b0;
                if (|pending) serve_id <= pick;
            end else if (ack) begin
                wait_cnt   <= '0;
                alarm      <= 1'b0;
                served_cnt <= served_cnt + CNT_W'(1);
            end else begin
                // Alarm is set on the same edge that brings wait_cnt to TIMEOUT.
                if (wait_cnt != WC_W'(TIMEOUT))     wait_cnt <= wait_cnt + WC_W'(1);
                if (wait_cnt == WC_W'(TIMEOUT - 1)) alarm    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nurse_call_arbiter.sv
// Directed self-checking bench for nurse_call_arbiter (TIMEOUT=8); expectations follow NURSE_CALL_RR_EN.
module tb_nurse_call_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] call;
    logic       ack;
    logic [2:0] led;
    logic       serve_valid;
    logic [1:0] serve_id;
    logic       alarm;
    logic [7:0] served_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned exp_seq [4];

    nurse_call_arbiter #(.N_BEDS(3), .ID_W(2), .TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .call(call), .ack(ack), .led(led),
        .serve_valid(serve_valid), .serve_id(serve_id), .alarm(alarm),
        .served_cnt(served_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
`ifdef NURSE_CALL_RR_EN
        exp_seq = '{1, 2, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        rst = 1'b0; call = '0; ack = 1'b0;
        step; step;
        check("rst_led", 32'(led), 0);
        check("rst_valid", 32'(serve_valid), 0);
        check("rst_id", 32'(serve_id), 0);
        check("rst_alarm", 32'(alarm), 0);
        check("rst_cnt", 32'(served_cnt), 0);
        rst = 1'b1;

        // Single call on bed 2, button held three cycles
        call = 3'b100; step;
        check("t1_led", 32'(led), 3'b100);
        check("t1_valid0", 32'(serve_valid), 0);
        step;
        check("t1_valid1", 32'(serve_valid), 1);
        check("t1_id", 32'(serve_id), 2);
        step;
        call = '0; ack = 1'b1; step; ack = 1'b0;
        check("t1_led_clr", 32'(led), 0);
        check("t1_cnt", 32'(served_cnt), 1);
        check("t1_valid_drop", 32'(serve_valid), 0);

        // All three beds at once, grants 0,1,2 with an idle cycle between
        call = 3'b111; step; call = '0; step;
        check("t2_g0_valid", 32'(serve_valid), 1);
        check("t2_g0_id", 32'(serve_id), 0);
        ack = 1'b1; step; ack = 1'b0;
        check("t2_idle0", 32'(serve_valid), 0);
        check("t2_led0", 32'(led), 3'b110);
        step;
        check("t2_g1_id", 32'(serve_id), 1);
        check("t2_g1_valid", 32'(serve_valid), 1);
        ack = 1'b1; step; ack = 1'b0;
        check("t2_idle1", 32'(serve_valid), 0);
        check("t2_led1", 32'(led), 3'b100);
        step;
        check("t2_g2_id", 32'(serve_id), 2);
        ack = 1'b1; step; ack = 1'b0;
        check("t2_led2", 32'(led), 0);
        check("t2_cnt", 32'(served_cnt), 4);

        // Alarm after 8 unacknowledged cycles
        call = 3'b010; step; call = '0; step;
        check("t3_valid", 32'(serve_valid), 1);
        check("t3_alarm0", 32'(alarm), 0);
        for (int i = 0; i < 7; i++) step;
        check("t3_alarm7", 32'(alarm), 0);
        step;
        check("t3_alarm8", 32'(alarm), 1);
        step; step; step;
        check("t3_alarm_hold", 32'(alarm), 1);
        ack = 1'b1; step; ack = 1'b0;
        check("t3_alarm_clr", 32'(alarm), 0);
        check("t3_cnt", 32'(served_cnt), 5);

        // No preemption, then held button does not re-pend
        call = 3'b100; step; call = '0; step;
        call = 3'b001; step; call = '0; step;
        check("t4_nopre_id", 32'(serve_id), 2);
        check("t4_led", 32'(led), 3'b101);
        ack = 1'b1; step; ack = 1'b0;
        check("t4_led_after", 32'(led), 3'b001);
        step;
        check("t4_next_id", 32'(serve_id), 0);
        check("t4_next_valid", 32'(serve_valid), 1);
        ack = 1'b1; step; ack = 1'b0;
        call = 3'b010; step; step;
        check("t4_hold_id", 32'(serve_id), 1);
        ack = 1'b1; step; ack = 1'b0;
        check("t4_hold_led", 32'(led), 0);
        step; step;
        check("t4_hold_led2", 32'(led), 0);
        check("t4_hold_valid", 32'(serve_valid), 0);
        call = '0; step;
        call = 3'b010; step;
        check("t4_repress_led", 32'(led), 3'b010);
        call = '0; step;
        check("t4_repress_id", 32'(serve_id), 1);
        ack = 1'b1; step; ack = 1'b0;
        check("t4_cnt", 32'(served_cnt), 9);

        // Asynchronous reset in the middle of a grant
        call = 3'b011; step; call = '0; step;
        check("t6_pre_valid", 32'(serve_valid), 1);
        #2 rst = 1'b0;
        #1;
        check("t6_async_led", 32'(led), 0);
        check("t6_async_valid", 32'(serve_valid), 0);
        check("t6_async_cnt", 32'(served_cnt), 0);
        check("t6_async_alarm", 32'(alarm), 0);
        step; rst = 1'b1;

        // ack while idle is ignored
        ack = 1'b1; step; ack = 1'b0;
        check("t6_idle_ack_cnt", 32'(served_cnt), 0);
        check("t6_idle_ack_valid", 32'(serve_valid), 0);

        // Arbitration with all beds re-pressed on every ack
        call = 3'b111; step; call = '0; step;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("t5_grant%0d", g), 32'(serve_id), exp_seq[g]);
            if (g < 3) begin
                ack = 1'b1; call = 3'b111; step; ack = 1'b0; call = '0;
                check($sformatf("t5_led%0d", g), 32'(led), 3'b111);
                step;
            end
        end
        ack = 1'b1; step; ack = 1'b0;
        check("t5_cnt", 32'(served_cnt), 4);

        rst = 1'b0; step; rst = 1'b1;
        check("t7_cnt_rst", 32'(served_cnt), 0);

        // served_cnt wraps 255 -> 0
        for (int n = 0; n < 255; n++) begin
            call = 3'b100; step; call = '0; step;
            ack = 1'b1; step; ack = 1'b0;
        end
        check("t7_cnt_255", 32'(served_cnt), 255);
        call = 3'b100; step; call = '0; step;
        ack = 1'b1; step; ack = 1'b0;
        check("t7_cnt_wrap", 32'(served_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
